// File: rtl/rv32_id_decoder_pkg.sv
// rv32_id_decoder_pkg: RV32IM opcode constants and opcode classification helpers.
package rv32_id_decoder_pkg;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_IMM     = 7'b0010011;
   localparam logic [6:0] OP_REG     = 7'b0110011;
   localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

   function automatic logic writes_rd(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
   endfunction

   function automatic logic reads_rs(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_BRANCH, OP_STORE};
   endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: combinational RV32 immediate generator (instruction -> imm32, raw imm12).
module rv32_imm_gen
   import rv32_id_decoder_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [31:0] imm32,
   output logic [11:0] imm12
);

   logic [31:0] i;
   assign i = instruction;

   always_comb begin
      imm32 = '0;
      case (i[6:0])
         OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{i[31]}}, i[31:20]};
         OP_STORE:                 imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
         OP_BRANCH:                imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm32 = {i[31:12], 12'b0};
         OP_JAL:                   imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:                  imm32 = '0;
      endcase
   end

   assign imm12 = (i[6:0] == OP_STORE) ? {i[31:25], i[11:7]} : i[31:20];

endmodule

// File: rtl/rv32_id_decoder.sv
// rv32_id_decoder: RV32IM decode stage with next-PC mux and ID/EX register bank.
// Define ENC_CUSTOM_EN to decode custom-0 (0001011) as an R-type encryption op.
module rv32_id_decoder
   import rv32_id_decoder_pkg::*;
#(
   parameter int ADDRESS_BITS = 16
)
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDRESS_BITS-1:0] pc,
   input  logic [31:0]             instruction,
   input  logic [ADDRESS_BITS-1:0] JALR_target,
   input  logic                    branch,
   output logic [ADDRESS_BITS-1:0] target_pc,
   output logic [6:0]              op,
   output logic [2:0]              funct3,
   output logic [6:0]              funct7,
   output logic [4:0]              read_sel1,
   output logic [4:0]              read_sel2,
   output logic [4:0]              write_sel,
   output logic                    wen,
   output logic                    en,
   output logic [31:0]             imm32,
   output logic [ADDRESS_BITS-1:0] pc_o,
   output logic [11:0]             imm12
);

   logic [6:0]              opcode;
   logic                    custom;
   logic                    wen_d;
   logic [31:0]             imm32_d;
   logic [11:0]             imm12_d;
   logic [ADDRESS_BITS-1:0] pc_seq;
   logic [ADDRESS_BITS-1:0] pc_rel;

   assign opcode    = instruction[6:0];
   assign read_sel1 = instruction[19:15];
   assign read_sel2 = instruction[24:20];

`ifdef ENC_CUSTOM_EN
   assign custom = (opcode == OP_CUSTOM0);
`else
   assign custom = 1'b0;
`endif

   assign wen_d = writes_rd(opcode) | custom;
   assign en    = reads_rs(opcode) | custom;

   rv32_imm_gen u_imm_gen (
      .instruction(instruction),
      .imm32      (imm32_d),
      .imm12      (imm12_d)
   );

   // imm32_d already holds immJ for JAL and immB for branches, so one adder serves both
   assign pc_seq = pc + ADDRESS_BITS'(4);
   assign pc_rel = pc + imm32_d[ADDRESS_BITS-1:0];

   assign target_pc = (opcode == OP_JAL)              ? pc_rel      :
                      (opcode == OP_JALR)             ? JALR_target :
                      (opcode == OP_BRANCH && branch) ? pc_rel      : pc_seq;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op        <= '0;
         funct3    <= '0;
         funct7    <= '0;
         write_sel <= '0;
         wen       <= 1'b0;
         imm32     <= '0;
         imm12     <= '0;
         pc_o      <= '0;
      end else begin
         op        <= opcode;
         funct3    <= instruction[14:12];
         funct7    <= instruction[31:25];
         write_sel <= instruction[11:7];
         wen       <= wen_d;
         imm32     <= imm32_d;
         imm12     <= imm12_d;
         pc_o      <= pc;
      end
   end

endmodule

// File: tb/tb_rv32_id_decoder.sv
// tb_rv32_id_decoder: table-driven and randomized self-checking bench for rv32_id_decoder.
module tb_rv32_id_decoder;

   localparam int AB = 16;
`ifdef ENC_CUSTOM_EN
   localparam bit CUST = 1'b1;
`else
   localparam bit CUST = 1'b0;
`endif

   typedef struct packed {
      logic [AB-1:0] pc;
      logic [31:0]   ins;
      logic [AB-1:0] jt;
      logic          br;
      logic [AB-1:0] tgt;
      logic [6:0]    op;
      logic [2:0]    f3;
      logic [6:0]    f7;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [4:0]    rd;
      logic          wen;
      logic          en;
      logic [31:0]   imm32;
      logic [11:0]   imm12;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset;
   logic [AB-1:0] pc;
   logic [31:0]   instruction;
   logic [AB-1:0] jalr_target;
   logic          branch;
   logic [AB-1:0] target_pc;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [4:0]    read_sel1;
   logic [4:0]    read_sel2;
   logic [4:0]    write_sel;
   logic          wen;
   logic          en;
   logic [31:0]   imm32;
   logic [AB-1:0] pc_o;
   logic [11:0]   imm12;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   rv32_id_decoder #(.ADDRESS_BITS(AB)) dut (
      .clock      (clock),
      .reset      (reset),
      .pc         (pc),
      .instruction(instruction),
      .JALR_target(jalr_target),
      .branch     (branch),
      .target_pc  (target_pc),
      .op         (op),
      .funct3     (funct3),
      .funct7     (funct7),
      .read_sel1  (read_sel1),
      .read_sel2  (read_sel2),
      .write_sel  (write_sel),
      .wen        (wen),
      .en         (en),
      .imm32      (imm32),
      .pc_o       (pc_o),
      .imm12      (imm12)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: immediates rebuilt as signed weighted sums of instruction bits
   function automatic vec_t model(input logic [AB-1:0] p, input logic [31:0] x,
                                  input logic [AB-1:0] jt, input logic br);
      vec_t v;
      logic [31:0] sgn12, sgn13, sgn21, imm;
      logic [6:0] o;
      o     = x[6:0];
      sgn12 = x[31] ? 32'd4096 : 32'd0;
      sgn13 = x[31] ? 32'd4096 : 32'd0;
      sgn21 = x[31] ? 32'd1048576 : 32'd0;
      if (o inside {7'h13, 7'h03, 7'h67})
         imm = 32'(x[31:20]) - sgn12;
      else if (o == 7'h23)
         imm = 32'(x[31:25]) * 32 + 32'(x[11:7]) - sgn12;
      else if (o == 7'h63)
         imm = 32'(x[7]) * 2048 + 32'(x[30:25]) * 32 + 32'(x[11:8]) * 2 - sgn13;
      else if (o inside {7'h37, 7'h17})
         imm = x & 32'hFFFFF000;
      else if (o == 7'h6F)
         imm = 32'(x[19:12]) * 4096 + 32'(x[20]) * 2048 + 32'(x[30:21]) * 2 - sgn21;
      else
         imm = 32'd0;
      v.pc    = p;
      v.ins   = x;
      v.jt    = jt;
      v.br    = br;
      v.op    = o;
      v.f3    = x[14:12];
      v.f7    = x[31:25];
      v.rs1   = x[19:15];
      v.rs2   = x[24:20];
      v.rd    = x[11:7];
      v.imm32 = imm;
      v.imm12 = (o == 7'h23) ? {x[31:25], x[11:7]} : x[31:20];
      v.wen   = (o inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) || (CUST && o == 7'h0B);
      v.en    = (o inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h63, 7'h23}) || (CUST && o == 7'h0B);
      if (o == 7'h6F)                 v.tgt = AB'(32'(p) + imm);
      else if (o == 7'h67)            v.tgt = jt;
      else if (o == 7'h63 && br)      v.tgt = AB'(32'(p) + imm);
      else                            v.tgt = AB'(32'(p) + 32'd4);
      return v;
   endfunction

   task automatic apply(input string tag, input vec_t v);
      @(negedge clock);
      pc = v.pc; instruction = v.ins; jalr_target = v.jt; branch = v.br;
      #1;
      chk({tag, ".target_pc"}, 32'(target_pc), 32'(v.tgt));
      chk({tag, ".read_sel1"}, 32'(read_sel1), 32'(v.rs1));
      chk({tag, ".read_sel2"}, 32'(read_sel2), 32'(v.rs2));
      chk({tag, ".en"}, 32'(en), 32'(v.en));
      @(posedge clock);
      #1;
      chk({tag, ".op"}, 32'(op), 32'(v.op));
      chk({tag, ".funct3"}, 32'(funct3), 32'(v.f3));
      chk({tag, ".funct7"}, 32'(funct7), 32'(v.f7));
      chk({tag, ".write_sel"}, 32'(write_sel), 32'(v.rd));
      chk({tag, ".wen"}, 32'(wen), 32'(v.wen));
      chk({tag, ".imm32"}, imm32, v.imm32);
      chk({tag, ".imm12"}, 32'(imm12), 32'(v.imm12));
      chk({tag, ".pc_o"}, 32'(pc_o), 32'(v.pc));
   endtask

   task automatic chk_regs_zero(input string tag);
      chk({tag, ".op"}, 32'(op), 0);
      chk({tag, ".funct3"}, 32'(funct3), 0);
      chk({tag, ".funct7"}, 32'(funct7), 0);
      chk({tag, ".write_sel"}, 32'(write_sel), 0);
      chk({tag, ".wen"}, 32'(wen), 0);
      chk({tag, ".imm32"}, imm32, 0);
      chk({tag, ".imm12"}, 32'(imm12), 0);
      chk({tag, ".pc_o"}, 32'(pc_o), 0);
   endtask

   vec_t vt[10];
   logic [6:0] ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};

   initial begin
      //            pc        ins           jt       br    tgt      op     f3    f7     rs1    rs2    rd     wen   en    imm32         imm12
      vt[0] = '{16'h0000, 32'h00500113, 16'h0000, 1'b0, 16'h0004, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd2,  1'b1, 1'b1, 32'h00000005, 12'h005};
      vt[1] = '{16'h0100, 32'hFF718393, 16'h0000, 1'b0, 16'h0104, 7'h13, 3'd0, 7'h7F, 5'd3,  5'h17, 5'd7,  1'b1, 1'b1, 32'hFFFFFFF7, 12'hFF7};
      vt[2] = '{16'h0010, 32'h02728863, 16'h0000, 1'b1, 16'h0040, 7'h63, 3'd0, 7'h01, 5'd5,  5'd7,  5'd16, 1'b0, 1'b1, 32'h00000030, 12'h027};
      vt[3] = '{16'h0010, 32'h02728863, 16'h0000, 1'b0, 16'h0014, 7'h63, 3'd0, 7'h01, 5'd5,  5'd7,  5'd16, 1'b0, 1'b1, 32'h00000030, 12'h027};
      vt[4] = '{16'h0020, 32'h0221A023, 16'h0000, 1'b0, 16'h0024, 7'h23, 3'd2, 7'h01, 5'd3,  5'd2,  5'd0,  1'b0, 1'b1, 32'h00000020, 12'h020};
      vt[5] = '{16'h0030, 32'h000000E7, 16'h1234, 1'b1, 16'h1234, 7'h67, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  1'b1, 1'b1, 32'h00000000, 12'h000};
      vt[6] = '{16'h0004, 32'hFF9FF0EF, 16'h5555, 1'b0, 16'hFFFC, 7'h6F, 3'd7, 7'h7F, 5'd31, 5'h19, 5'd1,  1'b1, 1'b0, 32'hFFFFFFF8, 12'hFF9};
      vt[7] = '{16'hFFFC, 32'h12345537, 16'h0000, 1'b1, 16'h0000, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd10, 1'b1, 1'b0, 32'h12345000, 12'h123};
      vt[8] = '{16'h0040, 32'h0041A20B, 16'h0000, 1'b1, 16'h0044, 7'h0B, 3'd2, 7'h00, 5'd3,  5'd4,  5'd4,  CUST, CUST, 32'h00000000, 12'h004};
      vt[9] = '{16'h0200, 32'h00500113, 16'h0000, 1'b1, 16'h0204, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd2,  1'b1, 1'b1, 32'h00000005, 12'h005};

      reset = 1'b1; pc = '0; instruction = '0; jalr_target = '0; branch = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_regs_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      for (int k = 0; k < 10; k++) apply($sformatf("tbl%0d", k), vt[k]);

      // asynchronous reset between edges clears registers at once; comb paths keep working
      apply("pre_rst", vt[1]);
      #2 reset = 1'b1;
      #1;
      chk_regs_zero("async_rst");
      chk("async_rst.target_pc", 32'(target_pc), 32'h0104);
      chk("async_rst.read_sel1", 32'(read_sel1), 32'd3);
      @(posedge clock);
      #1;
      chk_regs_zero("held_rst");
      @(negedge clock);
      reset = 1'b0;
      apply("post_rst", vt[5]);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] r, w;
         logic [6:0]  o;
         r = $urandom;
         w = $urandom;
         o = (r[3:0] < 4'd10) ? ops[r[3:0]] : r[10:4];
         apply($sformatf("rnd%0d", n), model(w[AB-1:0], {w[31:7] ^ r[31:7], o}, r[31:32-AB], r[11]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
